// File: rtl/trena_seq_uc.sv
// trena_seq_uc -- control unit for the ultrasonic tape-measure datapath.
//
// Triggers a measurement, waits for its result (with an optional timeout),
// then walks the serial transmitter through a frame of N_CHARS characters
// using an index register. In continuous mode it waits INTERVALO cycles and
// starts the next measurement without another request.
//
// Ports:
//   clock, reset       rising-edge clock, asynchronous active-high reset
//   mensurar           start request (level, honoured in INICIAL and ERRO)
//   modo_continuo      1 = repeat frames automatically
//   pronto_medida      measurement finished (honoured in AGUARDA only)
//   pronto_serial      serial TX finished the current character
//   medir              one-cycle measurement trigger
//   partida_serial     one-cycle serial TX start
//   sel_letra          index of the character being sent
//   pronto             one-cycle frame-complete pulse
//   erro               high while in the sensor-timeout state
//   db_estado          state code for debug displays
module trena_seq_uc #(
  parameter int N_CHARS   = 4,
  parameter int SEL_W     = 2,
  parameter int TIMEOUT   = 10000,
  parameter int INTERVALO = 5000,
  parameter int CNT_W     = 24
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             mensurar,
  input  logic             modo_continuo,
  input  logic             pronto_medida,
  input  logic             pronto_serial,
  output logic             medir,
  output logic             partida_serial,
  output logic [SEL_W-1:0] sel_letra,
  output logic             pronto,
  output logic             erro,
  output logic [3:0]       db_estado
);

  // Encodings double as the debug display codes.
  typedef enum logic [3:0] {
    S_INICIAL   = 4'h0,
    S_DISPARA   = 4'h1,
    S_AGUARDA   = 4'h2,
    S_TRANSMITE = 4'h3,
    S_ESPERA    = 4'h4,
    S_INTERVALO = 4'h5,
    S_ERRO      = 4'hE,
    S_FINAL     = 4'hF
  } state_t;

  localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(N_CHARS - 1);
  // TIMEOUT = 0 wraps TO_LAST, but TO_EN masks the compare in that case.
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] IV_LAST  = CNT_W'(INTERVALO - 1);
  localparam bit               TO_EN    = (TIMEOUT != 0);

  state_t           state, next_state;
  logic [SEL_W-1:0] idx;
  logic [CNT_W-1:0] cnt;   // shared by the sensor timeout and the frame interval

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_INICIAL;
    else       state <= next_state;
  end

  // Character index and timeout/interval counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx <= '0;
      cnt <= '0;
    end else begin
      case (state)
        S_INICIAL, S_FINAL: idx <= '0;
        // On the last character idx holds; FINAL clears it next.
        S_ESPERA: if (pronto_serial && idx != IDX_LAST) idx <= idx + 1'b1;
        default: ;
      endcase
      case (state)
        S_DISPARA, S_FINAL: cnt <= '0;
        S_AGUARDA:          if (!pronto_medida) cnt <= cnt + 1'b1;
        S_INTERVALO:        if (modo_continuo)  cnt <= cnt + 1'b1;
        default: ;
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_INICIAL:   if (mensurar) next_state = S_DISPARA;
      S_DISPARA:   next_state = S_AGUARDA;
      S_AGUARDA: begin
        // A result arriving on the expiry cycle still wins.
        if (pronto_medida)                 next_state = S_TRANSMITE;
        else if (TO_EN && cnt == TO_LAST)  next_state = S_ERRO;
      end
      S_TRANSMITE: next_state = S_ESPERA;
      S_ESPERA:
        if (pronto_serial) next_state = (idx == IDX_LAST) ? S_FINAL : S_TRANSMITE;
      S_FINAL:     next_state = modo_continuo ? S_INTERVALO : S_INICIAL;
      S_INTERVALO: begin
        if (!modo_continuo)      next_state = S_INICIAL;
        else if (cnt == IV_LAST) next_state = S_DISPARA;
      end
      S_ERRO:      if (mensurar) next_state = S_DISPARA;
      default:     next_state = S_INICIAL;
    endcase
  end

  // Moore outputs
  always_comb begin
    medir          = 1'b0;
    partida_serial = 1'b0;
    pronto         = 1'b0;
    erro           = 1'b0;
    sel_letra      = '0;
    db_estado      = 4'hD;
    case (state)
      S_INICIAL:   db_estado = 4'h0;
      S_DISPARA:   begin db_estado = 4'h1; medir = 1'b1; end
      S_AGUARDA:   db_estado = 4'h2;
      S_TRANSMITE: begin db_estado = 4'h3; partida_serial = 1'b1; sel_letra = idx; end
      S_ESPERA:    begin db_estado = 4'h4; sel_letra = idx; end
      S_INTERVALO: db_estado = 4'h5;
      S_FINAL:     begin db_estado = 4'hF; pronto = 1'b1; end
      S_ERRO:      begin db_estado = 4'hE; erro = 1'b1; end
      default:     db_estado = 4'hD;
    endcase
  end

endmodule

// File: tb/tb_trena_seq_uc.sv
// Bench for trena_seq_uc: three instances (4, 6 and 1 characters) each run
// directed scenarios then random traffic, checked every cycle against a
// phase/countdown model of the control unit.
module tb_trena_seq_uc;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int n_pass = 0;
  int n_tot  = 0;
  int n_done = 0;

  localparam int P_IDLE = 0, P_TRIG = 1, P_WAITM = 2, P_SEND = 3,
                 P_TXW = 4, P_DONE = 5, P_GAP = 6, P_ERR = 7;

  task automatic chk(input int g, input string nm, input int act, input int want);
    n_tot++;
    if (act == want) n_pass++;
    else $display("FAIL u%0d %s: got %0d want %0d (t=%0t)", g, nm, act, want, $time);
  endtask

  function automatic int st_code(input int p);
    case (p)
      P_IDLE:  return 0;
      P_TRIG:  return 1;
      P_WAITM: return 2;
      P_SEND:  return 3;
      P_TXW:   return 4;
      P_GAP:   return 5;
      P_DONE:  return 15;
      P_ERR:   return 14;
      default: return 13;
    endcase
  endfunction

  function automatic int pack(input int dbv, input bit m, input bit p, input bit d,
                              input bit e, input int s);
    return dbv * 256 + (m ? 128 : 0) + (p ? 64 : 0) + (d ? 32 : 0) + (e ? 16 : 0) + s;
  endfunction

  function automatic int bad_order(input int q[$]);
    int b = 0;
    foreach (q[i]) if (q[i] != i) b++;
    return b;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : u
    localparam int N    = (g == 0) ? 4 : (g == 1) ? 6 : 1;
    localparam int SW   = (g == 1) ? 3 : (g == 0) ? 2 : 1;
    localparam int TO   = (g == 2) ? 30 : 50;
    localparam int IV   = (g == 2) ? 1 : 20;
    localparam int RSEL = (N >= 3) ? 2 : 0;

    logic rst, mens, mc, pm, ps;
    logic medir, part, pronto, erro;
    logic [SW-1:0] sel;
    logic [3:0] db;

    trena_seq_uc #(.N_CHARS(N), .SEL_W(SW), .TIMEOUT(TO), .INTERVALO(IV), .CNT_W(8)) dut (
      .clock(clock), .reset(rst), .mensurar(mens), .modo_continuo(mc),
      .pronto_medida(pm), .pronto_serial(ps), .medir(medir), .partida_serial(part),
      .sel_letra(sel), .pronto(pronto), .erro(erro), .db_estado(db));

    // Model: what the unit is doing, a countdown of cycles left in the
    // current wait, and how many characters have been sent this frame.
    int ph = P_IDLE, left = 0, ch = 0;
    always @(posedge clock or posedge rst) begin
      if (rst) begin
        ph <= P_IDLE; left <= 0; ch <= 0;
      end else begin
        case (ph)
          P_IDLE:  if (mens) ph <= P_TRIG;
          P_TRIG:  begin ph <= P_WAITM; left <= TO; end
          P_WAITM: if (pm) ph <= P_SEND;
                   else if (TO != 0) begin
                     left <= left - 1;
                     if (left == 1) ph <= P_ERR;
                   end
          P_SEND:  ph <= P_TXW;
          P_TXW:   if (ps) begin
                     ch <= ch + 1;
                     ph <= (ch + 1 == N) ? P_DONE : P_SEND;
                   end
          P_DONE:  begin
                     ch <= 0;
                     if (mc) begin ph <= P_GAP; left <= IV; end
                     else ph <= P_IDLE;
                   end
          P_GAP:   if (!mc) ph <= P_IDLE;
                   else begin
                     left <= left - 1;
                     if (left == 1) ph <= P_TRIG;
                   end
          P_ERR:   if (mens) ph <= P_TRIG;
          default: ph <= P_IDLE;
        endcase
      end
    end

    always @(negedge clock)
      chk(g, "cycle", pack(int'(db), medir, part, pronto, erro, int'(sel)),
          pack(st_code(ph), ph == P_TRIG, ph == P_SEND, ph == P_DONE, ph == P_ERR,
               (ph == P_SEND || ph == P_TXW) ? ch : 0));

    // Frame-level check: characters requested 0..N-1 in order.
    int slog[$];
    always @(negedge clock) begin
      if (rst) slog.delete();
      else begin
        if (part) slog.push_back(int'(sel));
        if (pronto) begin
          chk(g, "frame_chars", slog.size(), N);
          chk(g, "frame_order", bad_order(slog), 0);
          slog.delete();
        end
      end
    end

    // Sensor and serial responders.
    int pmc = 0, psc = 0, dm = 5, ds = 10;
    bit noise = 1'b0, no_pm = 1'b0, ps_tx = 1'b0;
    always @(negedge clock) begin
      pmc <= medir ? dm : (pmc > 0 ? pmc - 1 : 0);
      psc <= part  ? ds : (psc > 0 ? psc - 1 : 0);
      pm  <= (!no_pm && pmc == 1) || (noise && $urandom_range(0, 15) == 0);
      ps  <= (psc == 1) || (ps_tx && part) || (noise && $urandom_range(0, 15) == 0);
    end

    task automatic wait_pronto(input string nm);
      int k = 0;
      while (!pronto && k < 2000) begin @(negedge clock); k++; end
      chk(g, nm, int'(pronto), 1);
      @(negedge clock);
    endtask

    initial begin : stim
      int k, nmed, npart, np, t, lastp;
      rst = 1'b1; mens = 1'b0; mc = 1'b0;
      repeat (2) @(negedge clock);
      chk(g, "reset_db", int'(db), 0);
      chk(g, "reset_outs", int'(medir) + int'(part) + int'(pronto) + int'(erro) + int'(sel), 0);
      #2 rst = 1'b0;
      @(negedge clock);

      // Single frame
      mens = 1'b1; @(negedge clock); mens = 1'b0;
      chk(g, "start_medir", int'(medir), 1);
      nmed = 1; npart = 0; k = 0;
      while (!pronto && k < 1000) begin
        @(negedge clock); k++;
        nmed += int'(medir); npart += int'(part);
      end
      chk(g, "single_medir", nmed, 1);
      chk(g, "single_part", npart, N);
      chk(g, "single_pronto", int'(pronto), 1);
      chk(g, "frame_len", k, 6 + 11 * N);
      @(negedge clock);
      chk(g, "single_idle", int'(db), 0);

      // Continuous mode over three frames, then drop it during the gap
      mc = 1'b1; mens = 1'b1; @(negedge clock); mens = 1'b0;
      t = 0; np = 0; lastp = -1;
      while (np < 3 && t < 3000) begin
        if (medir && lastp >= 0) chk(g, "cont_gap", t - lastp, IV + 1);
        if (pronto) begin np++; lastp = t; end
        if (np < 3) begin @(negedge clock); t++; end
      end
      chk(g, "cont_frames", np, 3);
      @(negedge clock);
      chk(g, "cont_in_gap", int'(db), 5);
      mc = 1'b0;
      @(negedge clock);
      chk(g, "cont_drop_idle", int'(db), 0);
      nmed = 0;
      repeat (IV + 10) begin @(negedge clock); nmed += int'(medir); end
      chk(g, "cont_no_medir", nmed, 0);

      // Sensor timeout, hold in ERRO, recovery
      no_pm = 1'b1; mens = 1'b1; @(negedge clock); mens = 1'b0;
      @(negedge clock);
      k = 0;
      while (db != 4'hE && k < TO + 20) begin @(negedge clock); k++; end
      chk(g, "timeout_len", k, TO);
      chk(g, "timeout_erro", int'(erro), 1);
      no_pm = 1'b0;
      repeat (3) @(negedge clock);
      chk(g, "err_hold", int'(db), 14);
      mens = 1'b1; @(negedge clock); mens = 1'b0;
      chk(g, "err_exit_erro", int'(erro), 0);
      chk(g, "err_exit_medir", int'(medir), 1);
      wait_pronto("err_frame_done");

      // Result on the expiry cycle wins; pronto_serial in TRANSMITE ignored
      dm = TO; ps_tx = 1'b1;
      @(negedge clock);
      mens = 1'b1; @(negedge clock); mens = 1'b0;
      repeat (TO + 1) @(negedge clock);
      chk(g, "prio_tx", int'(db), 3);
      @(negedge clock);
      chk(g, "ps_ign_state", int'(db), 4);
      chk(g, "ps_ign_idx", int'(sel), 0);
      wait_pronto("prio_frame_done");
      ps_tx = 1'b0; dm = 5;

      // Asynchronous reset in ESPERA, then a clean frame
      @(negedge clock);
      mens = 1'b1; @(negedge clock); mens = 1'b0;
      k = 0;
      while (!(db == 4'h4 && int'(sel) == RSEL) && k < 1000) begin @(negedge clock); k++; end
      chk(g, "rst_reach_sel", int'(sel), RSEL);
      #3 rst = 1'b1;
      #1;
      chk(g, "rst_db", int'(db), 0);
      chk(g, "rst_outs", int'(medir) + int'(part) + int'(pronto) + int'(erro) + int'(sel), 0);
      @(negedge clock); #2 rst = 1'b0;
      repeat (12) @(negedge clock);
      mens = 1'b1; @(negedge clock); mens = 1'b0;
      wait_pronto("post_rst_frame");
      chk(g, "post_rst_idle", int'(db), 0);

      // Random traffic
      noise = 1'b1;
      for (int i = 0; i < 1500; i++) begin
        @(negedge clock);
        mens  = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 99) == 0) mc = ~mc;
        dm    = $urandom_range(1, TO + 4);
        ds    = $urandom_range(1, 6);
        no_pm = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 299) == 0) begin
          #2 rst = 1'b1;
          @(negedge clock);
          #2 rst = 1'b0;
        end
      end
      n_done++;
    end
  end

  initial begin : finish_ctl
    int k = 0;
    while (n_done < 3 && k < 40000) begin @(negedge clock); k++; end
    chk(-1, "all_done", n_done, 3);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
